// File: rtl/axis_dest_arb_pkg.sv
// Shared types and helpers for the AXI4-Stream TDEST packet arbiter.
//   state_e    : arbiter FSM state (StIdle, StXfer); other encodings are illegal.
//   MAX_PORTS  : largest supported requester count (also the number of debug slots).
//   IDX_W      : width of a requester index / round-robin pointer.
//   TDEST_IDLE : all-ones idle/discard TDEST code for a given width (up to 32 bits).
package axis_dest_arb_pkg;

    localparam int unsigned MAX_PORTS = 4;
    localparam int unsigned IDX_W     = 2;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StXfer = 2'b01
    } state_e;

    function automatic logic [31:0] TDEST_IDLE(input int unsigned width);
        if (width >= 32) begin
            return '1;
        end
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/axi4_stream_dest_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req_i  : request vector, one bit per requester
//   ptr_i  : index of the highest-priority requester for this pick
//   pick_o : one-hot winner (0 when nothing requests)
//   idx_o  : encoded winner index (0 when nothing requests)
//   any_o  : at least one request is present
module rr_pick
    import axis_dest_arb_pkg::*;
#(
    parameter int unsigned NumPorts = 4
) (
    input  logic [NumPorts-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [NumPorts-1:0] pick_o,
    output logic [IDX_W-1:0]    idx_o,
    output logic                any_o
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back towards ptr_i so the closest
    // requesting port (in wrap order) is the last, and therefore winning, assignment.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        cand   = '0;
        any_o  = |req_i;
        for (int k = int'(NumPorts) - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(ptr_i) + k) % int'(NumPorts));
            if (req_i[cand]) begin
                pick_o       = '0;
                pick_o[cand] = 1'b1;
                idx_o        = cand;
            end
        end
    end

endmodule

// File: rtl/axi4_stream_dest_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI4-Stream master between up to
// four requesters. A requester is granted at a packet boundary, its TDEST is
// latched, and the grant is held until the TLAST handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   S_AXIS_*        : per-requester slave streams (data/dest packed by index)
//   M_AXIS_*        : merged master stream; TDEST is all-ones when not valid
//   grant           : one-hot current owner, zero while idle
//   debug           : per-requester 32-bit packet counters at [32*i +: 32]
// Optional feature: define AXIS_DEST_ARB_STATS_EN to build the packet counters;
// otherwise debug is tied to zero.
module axi4_stream_dest_arbiter
    import axis_dest_arb_pkg::*;
#(
    parameter int unsigned C_NUM_PORTS       = 4,
    parameter int unsigned C_AXIS_DEST_WIDTH = 2,
    parameter int unsigned C_AXIS_DATA_WIDTH = 64
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [C_NUM_PORTS-1:0]                    S_AXIS_TVALID,
    output logic [C_NUM_PORTS-1:0]                    S_AXIS_TREADY,
    input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]  S_AXIS_TDATA,
    input  logic [C_NUM_PORTS-1:0]                    S_AXIS_TLAST,
    input  logic [C_NUM_PORTS*C_AXIS_DEST_WIDTH-1:0]  S_AXIS_TDEST,
    output logic                                      M_AXIS_TVALID,
    input  logic                                      M_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]              M_AXIS_TDATA,
    output logic                                      M_AXIS_TLAST,
    output logic [C_AXIS_DEST_WIDTH-1:0]              M_AXIS_TDEST,
    output logic [C_NUM_PORTS-1:0]                    grant,
    output logic [127:0]                              debug
);

    localparam logic [C_AXIS_DEST_WIDTH-1:0] TdestIdle =
        C_AXIS_DEST_WIDTH'(TDEST_IDLE(C_AXIS_DEST_WIDTH));
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(C_NUM_PORTS - 1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               ptr_q, ptr_d;
    logic [IDX_W-1:0]               gidx_q, gidx_d;
    logic [C_NUM_PORTS-1:0]         grant_q, grant_d;
    logic [C_AXIS_DEST_WIDTH-1:0]   tdest_q, tdest_d;

    logic [C_NUM_PORTS-1:0]         pick;
    logic [IDX_W-1:0]               pick_idx;
    logic                           pick_any;
    logic                           pkt_done;

    rr_pick #(
        .NumPorts (C_NUM_PORTS)
    ) u_rr_pick (
        .req_i  (S_AXIS_TVALID),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Final beat of the owned packet is accepted downstream this cycle.
    assign pkt_done = (state_q == StXfer) && S_AXIS_TVALID[gidx_q] && M_AXIS_TREADY
                      && S_AXIS_TLAST[gidx_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            tdest_q <= TdestIdle;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
            tdest_q <= tdest_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        tdest_d = tdest_q;
        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d = StXfer;
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    tdest_d = S_AXIS_TDEST[pick_idx*C_AXIS_DEST_WIDTH +: C_AXIS_DEST_WIDTH];
                end
            end
            StXfer: begin
                // A withdrawn TVALID never releases the grant; only TLAST does.
                if (pkt_done) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = (gidx_q == LastIdx) ? '0 : gidx_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        S_AXIS_TREADY = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;
        M_AXIS_TLAST  = 1'b0;
        M_AXIS_TDEST  = TdestIdle;
        if (state_q == StXfer) begin
            S_AXIS_TREADY = grant_q & {C_NUM_PORTS{M_AXIS_TREADY}};
            M_AXIS_TVALID = S_AXIS_TVALID[gidx_q];
            M_AXIS_TDATA  = S_AXIS_TDATA[gidx_q*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
            M_AXIS_TLAST  = S_AXIS_TLAST[gidx_q];
            if (S_AXIS_TVALID[gidx_q]) begin
                M_AXIS_TDEST = tdest_q;
            end
        end
    end

    assign grant = (state_q == StXfer) ? grant_q : '0;

`ifdef AXIS_DEST_ARB_STATS_EN
    logic [31:0] pkt_cnt_q [MAX_PORTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MAX_PORTS; i++) begin
                pkt_cnt_q[i] <= '0;
            end
        end else if (pkt_done) begin
            for (int unsigned i = 0; i < MAX_PORTS; i++) begin
                if ((i < C_NUM_PORTS) && (gidx_q == IDX_W'(i))) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + 32'd1;
                end
            end
        end
    end

    always_comb begin
        debug = '0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (i < C_NUM_PORTS) begin
                debug[32*i +: 32] = pkt_cnt_q[i];
            end
        end
    end
`else
    assign debug = '0;
`endif

endmodule
